// File: rtl/ps2_kb_ascii_fifo_if.sv
// ---------------------------------------------------------------------------
// ps2_kb_ascii_fifo_if
// Bundles the PS/2 line inputs and the CPU-side FIFO port of the keyboard
// front end.
//   slave  modport : used by ps2_kb_ascii_fifo (receives PS/2 lines and
//                    pop/clear, drives status/data/full/count/overflow)
//   master modport : used by whatever drives the keyboard lines and reads
//                    characters (CPU I/O port, testbench)
// Signals:
//   PS2Clk, PS2Data   raw asynchronous keyboard clock/data
//   KB_read_en        pop request (honoured only while KB_status=1)
//   KB_clear          synchronous flush
//   KB_status         FIFO non-empty
//   KB_data           FIFO head, 0 while empty
//   buf_full          FIFO holds DEPTH entries
//   KB_count          current occupancy
//   overflow          sticky character-dropped flag
// ---------------------------------------------------------------------------
interface ps2_kb_ascii_fifo_if #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 7
);
    logic                   PS2Clk;
    logic                   PS2Data;
    logic                   KB_read_en;
    logic                   KB_clear;
    logic                   KB_status;
    logic [DATA_W-1:0]      KB_data;
    logic                   buf_full;
    logic [$clog2(DEPTH):0] KB_count;
    logic                   overflow;

    modport master (
        output PS2Clk, PS2Data, KB_read_en, KB_clear,
        input  KB_status, KB_data, buf_full, KB_count, overflow
    );

    modport slave (
        input  PS2Clk, PS2Data, KB_read_en, KB_clear,
        output KB_status, KB_data, buf_full, KB_count, overflow
    );
endinterface

// File: rtl/ps2_kb_ascii_fifo.sv
// ---------------------------------------------------------------------------
// ps2_kb_ascii_fifo
// PS/2 keyboard front end: synchronises and de-glitches the raw PS/2 lines,
// deframes scan-set-2 bytes, tracks E0/F0 prefixes, translates make codes to
// 7-bit ASCII and queues the characters in a first-word-fall-through FIFO.
//
// Ports:
//   clk     system clock, everything on the rising edge
//   rst_n   asynchronous active-low reset
//   kb      ps2_kb_ascii_fifo_if.slave (PS2Clk/PS2Data in, KB_read_en,
//           KB_clear in; KB_status, KB_data, buf_full, KB_count, overflow out)
//
// Parameters:
//   DEPTH       FIFO entries (power of 2, >= 2)
//   DATA_W      KB_data width (>= 7, upper bits read 0)
//   FILTER_LEN  clk cycles PS2Clk must be stable before an edge is accepted
//   TIMEOUT     idle clk cycles mid-frame before the receiver gives up
//
// Build option:
//   KB_SHIFT_EN  when defined, left/right shift (0x12/0x59) make/break codes
//                track a shift state and letters are queued in upper case
//                while it is held. When undefined there is no shift state
//                and shift codes are simply unmapped.
// ---------------------------------------------------------------------------
module ps2_kb_ascii_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_W     = 7,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ps2_kb_ascii_fifo_if.slave    kb
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    // Scan code -> {hit, ascii}. Letters are grouped first so that the shift
    // adjustment only ever touches a-z.
    function automatic logic [7:0] map_code(input logic [7:0] code,
                                            input logic       shift);
        logic [6:0] lc;
        logic       hit;
        logic       letter;
        lc     = 7'h00;
        hit    = 1'b1;
        letter = 1'b1;
        case (code)
            8'h1C: lc = 7'h61;  8'h32: lc = 7'h62;  8'h21: lc = 7'h63;
            8'h23: lc = 7'h64;  8'h24: lc = 7'h65;  8'h2B: lc = 7'h66;
            8'h34: lc = 7'h67;  8'h33: lc = 7'h68;  8'h43: lc = 7'h69;
            8'h3B: lc = 7'h6A;  8'h42: lc = 7'h6B;  8'h4B: lc = 7'h6C;
            8'h3A: lc = 7'h6D;  8'h31: lc = 7'h6E;  8'h44: lc = 7'h6F;
            8'h4D: lc = 7'h70;  8'h15: lc = 7'h71;  8'h2D: lc = 7'h72;
            8'h1B: lc = 7'h73;  8'h2C: lc = 7'h74;  8'h3C: lc = 7'h75;
            8'h2A: lc = 7'h76;  8'h1D: lc = 7'h77;  8'h22: lc = 7'h78;
            8'h35: lc = 7'h79;  8'h1A: lc = 7'h7A;
            default: letter = 1'b0;
        endcase
        if (!letter) begin
            case (code)
                8'h45: lc = 7'h30;  8'h16: lc = 7'h31;  8'h1E: lc = 7'h32;
                8'h26: lc = 7'h33;  8'h25: lc = 7'h34;  8'h2E: lc = 7'h35;
                8'h36: lc = 7'h36;  8'h3D: lc = 7'h37;  8'h3E: lc = 7'h38;
                8'h46: lc = 7'h39;
                8'h29: lc = 7'h20;  8'h5A: lc = 7'h0D;  8'h66: lc = 7'h08;
                default: hit = 1'b0;
            endcase
        end
        if (letter && shift) begin
            lc = lc - 7'h20;
        end
        return {hit, lc};
    endfunction

    // ---- stage p0/p1: two-flop synchronisers ------------------------------
    logic ps2c_p0, ps2c_p1, ps2d_p0, ps2d_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps2c_p0 <= 1'b1;
            ps2c_p1 <= 1'b1;
            ps2d_p0 <= 1'b1;
            ps2d_p1 <= 1'b1;
        end else begin
            ps2c_p0 <= kb.PS2Clk;
            ps2c_p1 <= ps2c_p0;
            ps2d_p0 <= kb.PS2Data;
            ps2d_p1 <= ps2d_p0;
        end
    end

    // ---- stage p2: clock de-glitch and falling-edge detect ----------------
    // filt_cnt counts consecutive samples that disagree with the filtered
    // level; the level flips on the FILTER_LEN-th one.
    logic          filt_clk_p2;
    logic          vld_p2;
    logic          bit_p2;
    logic [FW-1:0] filt_cnt;
    logic          filt_flip;

    assign filt_flip = (ps2c_p1 != filt_clk_p2) && (filt_cnt == F_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_clk_p2 <= 1'b1;
            filt_cnt    <= '0;
            vld_p2      <= 1'b0;
        end else begin
            vld_p2 <= filt_flip && filt_clk_p2;
            if (ps2c_p1 == filt_clk_p2 || filt_flip) begin
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
            if (filt_flip) begin
                filt_clk_p2 <= ps2c_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (filt_flip) begin
            bit_p2 <= ps2d_p1;
        end
    end

    // ---- stage p3: frame receiver -----------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    rx_state_t     rx_state;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          vld_p3;
    logic [7:0]    byte_p3;
    logic          par_p3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            bit_cnt  <= '0;
            tmo_cnt  <= '0;
            vld_p3   <= 1'b0;
        end else begin
            vld_p3 <= 1'b0;
            if (kb.KB_clear) begin
                rx_state <= RX_IDLE;
                tmo_cnt  <= '0;
            end else if (vld_p2) begin
                tmo_cnt <= '0;
                case (rx_state)
                    RX_IDLE: begin
                        if (!bit_p2) begin
                            rx_state <= RX_DATA;
                            bit_cnt  <= '0;
                        end
                    end
                    RX_DATA: begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            rx_state <= RX_PARITY;
                        end
                    end
                    RX_PARITY: rx_state <= RX_STOP;
                    default: begin
                        // odd parity over data+parity and a high stop bit
                        vld_p3   <= (^{byte_p3, par_p3}) && bit_p2;
                        rx_state <= RX_IDLE;
                    end
                endcase
            end else if (rx_state != RX_IDLE) begin
                if (tmo_cnt == T_LAST) begin
                    rx_state <= RX_IDLE;
                    tmo_cnt  <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    // LSB arrives first, so shift in from the top.
    always_ff @(posedge clk) begin
        if (vld_p2 && rx_state == RX_DATA) begin
            byte_p3 <= {bit_p2, byte_p3[7:1]};
        end
        if (vld_p2 && rx_state == RX_PARITY) begin
            par_p3 <= bit_p2;
        end
    end

    // ---- stage p4: prefix tracking, translation and FIFO push -------------
    logic       ext_q;
    logic       brk_q;
    logic       shift_w;
    logic       is_final;
    logic       is_shift_code;
    logic [7:0] map_w;
    logic       push_req;

    assign is_final      = vld_p3 && (byte_p3 != 8'hE0) && (byte_p3 != 8'hF0);
    assign is_shift_code = (byte_p3 == 8'h12) || (byte_p3 == 8'h59);
    assign map_w         = map_code(byte_p3, shift_w);
    assign push_req      = is_final && !ext_q && !brk_q && map_w[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (kb.KB_clear) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (vld_p3) begin
            if (byte_p3 == 8'hE0) begin
                ext_q <= 1'b1;
            end else if (byte_p3 == 8'hF0) begin
                brk_q <= 1'b1;
            end else begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

`ifdef KB_SHIFT_EN
    logic shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= 1'b0;
        end else if (kb.KB_clear) begin
            shift_q <= 1'b0;
        end else if (is_final && !ext_q && is_shift_code) begin
            shift_q <= !brk_q;
        end
    end

    assign shift_w = shift_q;
`else
    assign shift_w = 1'b0;
`endif

    // ---- FIFO --------------------------------------------------------------
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [6:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          ovf_q;
    logic          empty;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = kb.KB_read_en && !empty && !kb.KB_clear;
    assign do_push = push_req && (!full || do_pop) && !kb.KB_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else if (kb.KB_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (push_req && full && !do_pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= map_w[6:0];
        end
    end

    assign kb.KB_status = !empty;
    assign kb.KB_data   = empty ? '0 : DATA_W'(mem[rd_ptr[AW-1:0]]);
    assign kb.buf_full  = full;
    assign kb.KB_count  = wr_ptr - rd_ptr;
    assign kb.overflow  = ovf_q;

endmodule

// File: doc/ps2_kb_ascii_fifo.md
Name: ps2_kb_ascii_fifo

Overview:
Parametrised successor to the keyboard front end. One clock domain: samples raw PS/2 clock/data, deframes scan-set-2 bytes, tracks E0/F0 prefixes, translates make codes to 7-bit ASCII, and queues characters in a first-word-fall-through FIFO.
The CPU-side I/O port reads the FIFO through KB_read_en/KB_status/KB_data. Adds what the previous block lacked: configurable depth, real buffering with full/overflow/count reporting, frame error recovery, and a working clear.

Parameters:
DEPTH, 16, FIFO entries; power of 2, >=2
DATA_W, 7, width of KB_data; >=7; bits above 6 read 0
FILTER_LEN, 8, clk cycles PS2Clk must be stable before an edge is accepted
TIMEOUT, 100000, idle clk cycles mid-frame before the bit counter is abandoned

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
PS2Clk  in  1  raw keyboard clock, asynchronous
PS2Data  in  1  raw keyboard data, asynchronous
KB_read_en  in  1  pop request, honoured only when KB_status=1
KB_clear  in  1  synchronous flush
KB_status  out  1  FIFO non-empty
KB_data  out  DATA_W  FIFO head (valid while KB_status=1, else 0)
buf_full  out  1  FIFO holds DEPTH entries
KB_count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: a character was dropped because FIFO full

Behaviour:
- Reset (rst_n=0, async): FIFO empty, KB_status=0, KB_data=0, buf_full=0, KB_count=0, overflow=0, receiver IDLE, prefix flags and shift state cleared.
- Input conditioning:
  - PS2Clk/PS2Data each pass through a 2-FF synchroniser.
  - Filtered PS2Clk changes only after FILTER_LEN identical consecutive samples.
  - A falling edge of filtered PS2Clk samples PS2Data.
- Receiver FSM:
  - IDLE: a sampled 0 (start bit) moves to DATA; a sampled 1 stays in IDLE.
  - DATA: 8 bits, LSB first, then PARITY, then STOP.
  - STOP: odd parity ok and stop=1 emits byte_valid for one clk; any other case discards the byte silently. Both return to IDLE.
  - Timeout: TIMEOUT clk cycles without a falling edge while not in IDLE returns the FSM to IDLE.
- Decoder, on byte_valid:
  - 0xE0 sets ext; 0xF0 sets brk.
  - Any other byte is final: handled per the rules below, then ext and brk clear.
  - brk=1 final byte: no push, except shift release (0x12/0x59 with ext=0) clears shift.
  - ext=1 final byte: no push.
  - Make code lookup: letters a-z per set 2 (e.g. 0x1C->0x61, 0x32->0x62), digits 0-9 (0x45->0x30, 0x16->0x31 ... 0x46->0x39), 0x29->0x20, 0x5A->0x0D, 0x66->0x08.
  - Unmapped make codes: dropped.
  - Typematic repeats: pushed again (each make is one character).
- Push latency: character enters FIFO on the clk after byte_valid. KB_status rises the same edge (first-word fall-through).
- Pop: KB_read_en=1 and KB_status=1 advances the head at the rising edge. The next entry is visible on KB_data that edge. KB_read_en while empty is ignored, no underflow.
- Simultaneous push and pop:
  - Non-empty: both occur, KB_count unchanged.
  - Full: pop frees space, push accepted, overflow unchanged.
  - Empty: pop is ignored, push is accepted.
- Push when full without pop: character dropped, overflow<=1. overflow stays set until KB_clear or reset.
- Pointers: $clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH. full when MSBs differ and remaining bits are equal.
- KB_clear=1 (synchronous):
  - Empties the FIFO and clears overflow, ext, brk and shift. Receiver returns to IDLE.
  - A push or pop in the same cycle is discarded; clear wins.

Optional Feature:
KB_SHIFT_EN
- Defined: make 0x12 or 0x59 (ext=0) sets shift, release clears it. While shift=1, letters map to upper case (0x1C->0x41). Digits and other keys are unchanged.
- Undefined: shift codes are treated as unmapped and all letters are lower case. No shift register is synthesised.

Test Plan:
1. Frame 0x1C (data bits 0,0,1,1,1,0,0,0, parity 0, stop 1) -> KB_status=1, KB_data=0x61, KB_count=1. Then KB_read_en one cycle -> KB_status=0, KB_data=0.
2. Sequence 1C, F0 1C, E0 75, E0 F0 75 -> exactly one entry, 0x61.
3. DEPTH=4: send 1C,32,21,23,24 without reads -> buf_full=1, overflow=1, reads return 61,62,63,64. KB_clear then sets all outputs to 0.
4. Frame 0x1C with parity bit flipped -> no push. Half frame (5 bits) then idle > TIMEOUT, then valid 0x29 -> single entry 0x20.
5. Full FIFO with KB_read_en asserted the same cycle as a push -> KB_count stays DEPTH, overflow=0, FIFO order preserved.
6. KB_SHIFT_EN defined: 12, 1C, F0 12, 1C -> entries 0x41, 0x61. rst_n pulsed mid-frame -> all outputs 0 immediately, asynchronously.
